// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared constants and types for the LCD field writers:
//                ASCII codes, BCD word width and the field-writer state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

   // Packed BCD word width produced by the 12-bit binary-to-BCD converter
   localparam int BCD_W = 16;

   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_QMARK = 8'h3F;

   // Field-writer state encoding; code 3 is unused and recovers to IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EMIT = ST_EMIT,
      S_DONE = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_to_ascii
//  Description : Combinational mapping of one BCD nibble to an LCD character,
//                with optional leading-zero blanking and error detection.
//  Ports       : nibble       - BCD digit to convert
//                blank_en     - leading-zero blanking enabled
//                is_last      - this is the rightmost digit (never blanked)
//                seen_nonzero - a nonzero digit was already emitted
//                ascii_char   - character to write
//                is_err       - nibble is not a decimal digit (> 9)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_to_ascii
   import lcd_pkg::*;
#(
   parameter logic [7:0] BLANK_CHAR = CHAR_SPACE,
   parameter logic [7:0] ERR_CHAR   = CHAR_QMARK
) (
   input  logic [3:0] nibble,
   input  logic       blank_en,
   input  logic       is_last,
   input  logic       seen_nonzero,
   output logic [7:0] ascii_char,
   output logic       is_err
);

   always_comb begin
      is_err     = (nibble > 4'd9);
      ascii_char = CHAR_ZERO + {4'h0, nibble};
      if (is_err) begin
         ascii_char = ERR_CHAR;
      end else if (blank_en && (nibble == 4'd0) && !seen_nonzero && !is_last) begin
         ascii_char = BLANK_CHAR;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_to_lcd_chars.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_lcd_chars
//  Description : Writes one packed-BCD field into the LCD character buffer,
//                one character per digit, most significant digit first,
//                with leading-zero blanking and ready/valid back-pressure.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                bcd_in_valid/bcd_in   - field value (digit 0 in low nibble)
//                field_addr            - buffer address of leftmost char
//                in_ready              - idle, a new field can be accepted
//                char_valid/addr/data  - character write request
//                char_ready            - buffer accepts current character
//                field_done/field_err  - end-of-field pulse and error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_lcd_chars
   import lcd_pkg::*;
#(
   parameter int         NUM_DIGITS = 4,
   parameter int         ADDR_W     = 8,
   parameter logic [7:0] BLANK_CHAR = 8'h20,
   parameter logic [7:0] ERR_CHAR   = 8'h3F,
   parameter bit         LZ_BLANK   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bcd_in_valid,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [ADDR_W-1:0]       field_addr,
   output logic                    in_ready,
   output logic                    char_valid,
   output logic [ADDR_W-1:0]       char_addr,
   output logic [7:0]              char_data,
   input  logic                    char_ready,
   output logic                    field_done,
   output logic                    field_err
);

   localparam int W     = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NUM_DIGITS - 1);

   state_t              r_state;
   logic [W-1:0]        r_shift;
   logic [ADDR_W-1:0]   r_base;
   logic [CNT_W-1:0]    r_digit_cnt;
   logic                r_seen_nz;
   logic                r_err_acc;
   logic                r_char_valid;
   logic [ADDR_W-1:0]   r_char_addr;
   logic [7:0]          r_char_data;
   logic                r_field_done;
   logic                r_field_err;

   logic [3:0]          w_cur_nib;
   logic                w_cur_err;
   logic                w_cur_nz;
   logic                w_last;
   logic [W-1:0]        w_shift_next;
   logic [CNT_W-1:0]    w_cnt_next;
   logic [ADDR_W-1:0]   w_next_addr;
   logic [3:0]          w_cv_nib;
   logic                w_cv_seen;
   logic                w_cv_last;
   logic [7:0]          w_cv_char;
   logic                w_cv_err;

   assign w_cur_nib    = r_shift[W-1 -: 4];
   assign w_cur_err    = (w_cur_nib > 4'd9);
   assign w_cur_nz     = |w_cur_nib;
   assign w_last       = (r_digit_cnt == c_last_cnt);
   assign w_shift_next = r_shift << 4;
   assign w_cnt_next   = r_digit_cnt + CNT_W'(1);
   assign w_next_addr  = r_base + ADDR_W'(w_cnt_next);

   // One converter serves both the first character (straight from bcd_in at
   // accept) and every following character (the nibble that will be on top
   // after the current handshake shifts the register).
   always_comb begin
      w_cv_nib  = bcd_in[W-1 -: 4];
      w_cv_seen = 1'b0;
      w_cv_last = (NUM_DIGITS == 1);
      if (r_state == S_EMIT) begin
         w_cv_nib  = w_shift_next[W-1 -: 4];
         w_cv_seen = r_seen_nz | w_cur_nz;
         w_cv_last = (w_cnt_next == c_last_cnt);
      end
   end

   bcd_digit_to_ascii #(
      .BLANK_CHAR (BLANK_CHAR),
      .ERR_CHAR   (ERR_CHAR)
   ) u_digit (
      .nibble       (w_cv_nib),
      .blank_en     (LZ_BLANK),
      .is_last      (w_cv_last),
      .seen_nonzero (w_cv_seen),
      .ascii_char   (w_cv_char),
      .is_err       (w_cv_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_base       <= '0;
         r_digit_cnt  <= '0;
         r_seen_nz    <= 1'b0;
         r_err_acc    <= 1'b0;
         r_char_valid <= 1'b0;
         r_char_addr  <= '0;
         r_char_data  <= '0;
         r_field_done <= 1'b0;
         r_field_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_field_done <= 1'b0;
               r_field_err  <= 1'b0;
               if (bcd_in_valid) begin
                  r_shift      <= bcd_in;
                  r_base       <= field_addr;
                  r_digit_cnt  <= '0;
                  r_seen_nz    <= 1'b0;
                  r_err_acc    <= 1'b0;
                  r_char_valid <= 1'b1;
                  r_char_addr  <= field_addr;
                  r_char_data  <= w_cv_char;
                  r_state      <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (char_ready) begin
                  r_shift     <= w_shift_next;
                  r_digit_cnt <= w_cnt_next;
                  r_seen_nz   <= r_seen_nz | w_cur_nz;
                  r_err_acc   <= r_err_acc | w_cur_err;
                  if (w_last) begin
                     // Done pulse is visible during the DONE cycle itself
                     r_char_valid <= 1'b0;
                     r_field_done <= 1'b1;
                     r_field_err  <= r_err_acc | w_cur_err;
                     r_state      <= S_DONE;
                  end else begin
                     r_char_addr <= w_next_addr;
                     r_char_data <= w_cv_char;
                  end
               end
            end
            S_DONE: begin
               r_field_done <= 1'b0;
               r_field_err  <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: begin
               r_char_valid <= 1'b0;
               r_field_done <= 1'b0;
               r_field_err  <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign char_valid = r_char_valid;
   assign char_addr  = r_char_addr;
   assign char_data  = r_char_data;
   assign field_done = r_field_done;
   assign field_err  = r_field_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_lcd_chars.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_lcd_chars
//  Description : Self-checking bench for bcd_to_lcd_chars. Field vectors are
//                taken from a table; expected characters go to a scoreboard
//                queue and are compared on every buffer handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_lcd_chars;

   localparam int ND = 4;

   typedef struct {
      logic [15:0] bcd;
      logic [7:0]  addr;
      logic [31:0] chars;     // leftmost character in [31:24]
      bit          err;
      int          stall_at;  // character index to stall on, -1 for none
      int          stall_len;
      bit          poke;      // drive bcd_in_valid while busy
   } vec_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bcd_in_valid;
   logic [15:0] bcd_in;
   logic [7:0]  field_addr;
   logic        in_ready;
   logic        char_valid;
   logic [7:0]  char_addr;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        field_done;
   logic        field_err;

   logic        nb_valid;
   logic [15:0] nb_bcd;
   logic [7:0]  nb_addr;
   logic        nb_in_ready;
   logic        nb_char_valid;
   logic [7:0]  nb_char_addr;
   logic [7:0]  nb_char_data;
   logic        nb_field_done;
   logic        nb_field_err;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   bit   done_q[$];
   int   field_hs   = 0;
   int   stall_at   = -1;
   int   stall_left = 0;
   vec_t vecs[7];

   always #5 clk = ~clk;

   bcd_to_lcd_chars #(
      .NUM_DIGITS (ND),
      .ADDR_W     (8),
      .BLANK_CHAR (8'h20),
      .ERR_CHAR   (8'h3F),
      .LZ_BLANK   (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bcd_in_valid (bcd_in_valid),
      .bcd_in       (bcd_in),
      .field_addr   (field_addr),
      .in_ready     (in_ready),
      .char_valid   (char_valid),
      .char_addr    (char_addr),
      .char_data    (char_data),
      .char_ready   (char_ready),
      .field_done   (field_done),
      .field_err    (field_err)
   );

   bcd_to_lcd_chars #(
      .NUM_DIGITS (ND),
      .ADDR_W     (8),
      .BLANK_CHAR (8'h20),
      .ERR_CHAR   (8'h3F),
      .LZ_BLANK   (1'b0)
   ) dut_nb (
      .clk          (clk),
      .rst_n        (rst_n),
      .bcd_in_valid (nb_valid),
      .bcd_in       (nb_bcd),
      .field_addr   (nb_addr),
      .in_ready     (nb_in_ready),
      .char_valid   (nb_char_valid),
      .char_addr    (nb_char_addr),
      .char_data    (nb_char_data),
      .char_ready   (1'b1),
      .field_done   (nb_field_done),
      .field_err    (nb_field_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every handshake pops one expected character, every
   // done pulse pops one expected error flag; a stalled character must hold.
   initial begin
      logic [7:0] h_addr;
      logic [7:0] h_data;
      bit         have_hold;
      exp_t       e;
      have_hold = 1'b0;
      h_addr    = '0;
      h_data    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_hold = 1'b0;
         end else begin
            if (char_valid) begin
               if (have_hold) begin
                  check("hold_addr", char_addr, h_addr);
                  check("hold_data", char_data, h_data);
               end
               if (char_ready) begin
                  have_hold = 1'b0;
                  if (exp_q.size() == 0) begin
                     check("unexpected_char", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("char_addr", char_addr, e.addr);
                     check("char_data", char_data, e.data);
                  end
                  field_hs++;
               end else begin
                  have_hold = 1'b1;
                  h_addr    = char_addr;
                  h_data    = char_data;
               end
            end else begin
               have_hold = 1'b0;
            end
            if (field_done) begin
               if (done_q.size() == 0) check("spurious_done", 1, 0);
               else                    check("field_err", field_err, done_q.pop_front());
            end
         end
      end
   end

   // Buffer model: ready high except for a programmed stall on one character
   initial begin
      char_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (char_valid && (field_hs == stall_at) && (stall_left > 0)) begin
            char_ready = 1'b0;
            stall_left--;
         end else begin
            char_ready = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
   endtask

   task automatic start_field(input vec_t v, input bit expect_done);
      exp_t e;
      wait_idle();
      @(posedge clk);
      #1;
      bcd_in       = v.bcd;
      field_addr   = v.addr;
      bcd_in_valid = 1'b1;
      field_hs     = 0;
      stall_at     = v.stall_at;
      stall_left   = v.stall_len;
      for (int i = 0; i < ND; i++) begin
         e.addr = v.addr + 8'(i);
         e.data = v.chars[31-8*i -: 8];
         exp_q.push_back(e);
      end
      if (expect_done) done_q.push_back(v.err);
      @(posedge clk);
      #1;
      bcd_in_valid = 1'b0;
   endtask

   task automatic send_field(input vec_t v);
      int n;
      bit got;
      start_field(v, 1'b1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("latency_valid", char_valid, 1);
            check("busy_in_ready", in_ready, 0);
         end
         if (v.poke && n == 2) begin
            bcd_in_valid = 1'b1;
            bcd_in       = 16'h9999;
            field_addr   = 8'h77;
         end
         if (v.poke && n == 3) bcd_in_valid = 1'b0;
         if (field_done) got = 1'b1;
      end
      check("done_seen", got, 1);
      check("done_cycle", n, ND + 1 + v.stall_len);
      @(negedge clk);
      check("in_ready_after", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      int   n;
      vecs[0] = '{16'h0123, 8'h10, " 123", 1'b0, -1, 0, 1'b0};
      vecs[1] = '{16'h0000, 8'h20, "   0", 1'b0, -1, 0, 1'b0};
      vecs[2] = '{16'h1A05, 8'h30, "1?05", 1'b1, -1, 0, 1'b1};
      vecs[3] = '{16'h4095, 8'h40, "4095", 1'b0,  1, 3, 1'b0};
      vecs[4] = '{16'h1234, 8'hFE, "1234", 1'b0, -1, 0, 1'b0};
      vecs[5] = '{16'hF000, 8'h70, "?000", 1'b1, -1, 0, 1'b0};
      vecs[6] = '{16'h0909, 8'h80, " 909", 1'b0, -1, 0, 1'b0};

      rst_n        = 1'b0;
      bcd_in_valid = 1'b0;
      bcd_in       = '0;
      field_addr   = '0;
      nb_valid     = 1'b0;
      nb_bcd       = '0;
      nb_addr      = '0;

      @(negedge clk);
      check("rst_char_valid", char_valid, 0);
      check("rst_char_addr",  char_addr,  0);
      check("rst_char_data",  char_data,  0);
      check("rst_field_done", field_done, 0);
      check("rst_field_err",  field_err,  0);
      check("rst_in_ready",   in_ready,   1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Blanking disabled: every digit printed
      @(posedge clk);
      #1;
      nb_valid = 1'b1;
      nb_bcd   = 16'h0000;
      nb_addr  = 8'h60;
      @(posedge clk);
      #1;
      nb_valid = 1'b0;
      for (int i = 0; i < ND; i++) begin
         @(negedge clk);
         check("nb_valid", nb_char_valid, 1);
         check("nb_addr",  nb_char_addr, 8'h60 + 8'(i));
         check("nb_data",  nb_char_data, 8'h30);
      end
      @(negedge clk);
      check("nb_done", nb_field_done, 1);
      check("nb_err",  nb_field_err, 0);

      for (int k = 0; k < 7; k++) send_field(vecs[k]);

      // Reset after the second handshake abandons the field
      rv = '{16'h5678, 8'h50, "5678", 1'b0, -1, 0, 1'b0};
      start_field(rv, 1'b0);
      n = 0;
      while (field_hs < 2 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("mid_hs_reached", field_hs, 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_char_valid", char_valid, 0);
      check("midrst_char_addr",  char_addr,  0);
      check("midrst_char_data",  char_data,  0);
      check("midrst_field_done", field_done, 0);
      check("midrst_in_ready",   in_ready,   1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      rv = '{16'h0042, 8'h00, "  42", 1'b0, -1, 0, 1'b0};
      send_field(rv);

      check("exp_q_empty",  exp_q.size(),  0);
      check("done_q_empty", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
